// File: rtl/fcb_param_loader.sv
// Streams weight and bias words from the processor side into one FC datapath:
// weights go to the one-hot weight memories in order, then biases go to the bias FIFO.
module fcb_param_loader #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDRESS_BITS    = 15,
    parameter int IFM_DEPTH       = 80,
    parameter int ADDRESS_SIZE_WM = $clog2(IFM_DEPTH),
    parameter int NUMBER_OF_WM    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   riscv_data,
    output logic [ADDRESS_BITS-1:0] riscv_address,
    output logic [NUMBER_OF_WM-1:0] wm_enable_write,
    output logic                    bm_enable_write,
    output logic                    wm_addr_sel,
    output logic                    busy,
    output logic                    done
);
    // state  | meaning
    // IDLE   | no load; compute side owns the weight address
    // LOAD_W | accepting weight words, memory by memory
    // LOAD_B | accepting bias words, pushed to the bias FIFO

    localparam int MEM_BITS = (NUMBER_OF_WM > 1) ? $clog2(NUMBER_OF_WM) : 1;
    localparam logic [ADDRESS_SIZE_WM-1:0] ADDR_LAST = ADDRESS_SIZE_WM'(IFM_DEPTH - 1);
    localparam logic [MEM_BITS-1:0]        MEM_LAST  = MEM_BITS'(NUMBER_OF_WM - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        LOAD_B = 2'd2
    } state_t;

    state_t                     state;
    logic [ADDRESS_SIZE_WM-1:0] addr;
    logic [MEM_BITS-1:0]        mem;
    logic [MEM_BITS-1:0]        bidx;
    logic                       accept;

    assign in_ready    = (state != IDLE);
    assign accept      = in_valid && in_ready;
    // busy stays high through the cycle carrying the final strobe
    assign wm_addr_sel = ~busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            addr            <= '0;
            mem             <= '0;
            bidx            <= '0;
            riscv_data      <= '0;
            riscv_address   <= '0;
            wm_enable_write <= '0;
            bm_enable_write <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else begin
            wm_enable_write <= '0;
            bm_enable_write <= 1'b0;
            done            <= 1'b0;
            if (abort && state != IDLE) begin
                state <= IDLE;
                busy  <= 1'b0;
                addr  <= '0;
                mem   <= '0;
                bidx  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        busy <= 1'b0;
                        if (start && !abort) begin
                            state <= LOAD_W;
                            busy  <= 1'b1;
                            addr  <= '0;
                            mem   <= '0;
                            bidx  <= '0;
                        end
                    end
                    LOAD_W: begin
                        if (accept) begin
                            riscv_data      <= in_data;
                            riscv_address   <= ADDRESS_BITS'(addr);
                            wm_enable_write <= NUMBER_OF_WM'(1) << mem;
                            if (addr == ADDR_LAST) begin
                                addr <= '0;
                                if (mem == MEM_LAST) begin
                                    mem   <= '0;
                                    state <= LOAD_B;
                                end else begin
                                    mem <= mem + 1'b1;
                                end
                            end else begin
                                addr <= addr + 1'b1;
                            end
                        end
                    end
                    LOAD_B: begin
                        if (accept) begin
                            riscv_data      <= in_data;
                            riscv_address   <= ADDRESS_BITS'(bidx);
                            bm_enable_write <= 1'b1;
                            if (bidx == MEM_LAST) begin
                                bidx  <= '0;
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                bidx <= bidx + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fcb_param_loader.sv
// Directed bench for fcb_param_loader: full loads, backpressure, abort, async reset
// and ignored start requests, checked against a cycle model of the load stream.
module tb_fcb_param_loader;
    localparam int DEPTH = 80;
    localparam int NWM   = 10;
    localparam int NW    = DEPTH * NWM;
    localparam int TOTAL = NW + NWM;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] riscv_data;
    logic [14:0] riscv_address;
    logic [9:0]  wm_enable_write;
    logic        bm_enable_write;
    logic        wm_addr_sel;
    logic        busy;
    logic        done;

    fcb_param_loader dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .in_data         (in_data),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .riscv_data      (riscv_data),
        .riscv_address   (riscv_address),
        .wm_enable_write (wm_enable_write),
        .bm_enable_write (bm_enable_write),
        .wm_addr_sel     (wm_addr_sel),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_values();
        check_eq("rst_riscv_data", riscv_data, 0);
        check_eq("rst_riscv_address", riscv_address, 0);
        check_eq("rst_wm_enable_write", wm_enable_write, 0);
        check_eq("rst_bm_enable_write", bm_enable_write, 0);
        check_eq("rst_wm_addr_sel", wm_addr_sel, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_in_ready", in_ready, 0);
    endtask

    // model of the loader as seen from the stream side
    bit          m_ready = 1'b0;
    bit          p_strobe = 1'b0;
    bit          p_done = 1'b0;
    int          p_idx = 0;
    int          acc = 0;
    logic [31:0] p_data = '0;
    logic [31:0] m_data = '0;
    logic [14:0] m_addr = '0;
    logic [9:0]  e_wm;
    logic        e_bm;
    bit          m_busy;
    int          strobes = 0;
    int          dones = 0;

    always @(negedge clk) begin
        if (!reset) begin
            m_ready  = 1'b0;
            p_strobe = 1'b0;
            p_done   = 1'b0;
            acc      = 0;
            m_data   = '0;
            m_addr   = '0;
        end else begin
            e_wm = '0;
            e_bm = 1'b0;
            if (p_strobe) begin
                m_data = p_data;
                if (p_idx < NW) begin
                    e_wm   = 10'(1) << (p_idx / DEPTH);
                    m_addr = 15'(p_idx % DEPTH);
                end else begin
                    e_bm   = 1'b1;
                    m_addr = 15'(p_idx - NW);
                end
                strobes++;
            end
            m_busy = m_ready || p_done;
            check_eq("in_ready", in_ready, m_ready);
            check_eq("wm_enable_write", wm_enable_write, e_wm);
            check_eq("bm_enable_write", bm_enable_write, e_bm);
            check_eq("riscv_data", riscv_data, m_data);
            check_eq("riscv_address", riscv_address, m_addr);
            check_eq("done", done, p_done);
            check_eq("busy", busy, m_busy);
            check_eq("wm_addr_sel", wm_addr_sel, !m_busy);
            if (p_strobe && p_idx == 79) begin
                check_eq("edge79_wm", wm_enable_write, 10'h001);
                check_eq("edge79_addr", riscv_address, 79);
            end
            if (p_strobe && p_idx == 80) begin
                check_eq("edge80_wm", wm_enable_write, 10'h002);
                check_eq("edge80_addr", riscv_address, 0);
            end
            if (p_strobe && p_idx == 799) check_eq("edge799_wm", wm_enable_write, 10'h200);
            if (p_strobe && p_idx == 800) begin
                check_eq("edge800_bm", bm_enable_write, 1);
                check_eq("edge800_wm", wm_enable_write, 0);
            end
            if (done) dones++;

            p_strobe = 1'b0;
            p_done   = 1'b0;
            if (m_ready) begin
                if (abort) begin
                    m_ready = 1'b0;
                    acc     = 0;
                end else if (in_valid) begin
                    p_strobe = 1'b1;
                    p_idx    = acc;
                    p_data   = in_data;
                    acc++;
                    if (acc == TOTAL) begin
                        m_ready = 1'b0;
                        p_done  = 1'b1;
                        acc     = 0;
                    end
                end
            end else if (start && !abort) begin
                m_ready = 1'b1;
                acc     = 0;
            end
        end
    end

    // word value = stream index; negative *_at arguments disable that event
    task automatic run_load(input int gap_pct, input int abort_at, input int reset_at,
                            input bit start_with_valid, input int busy_start_at);
        int  i;
        int  cyc;
        bit  stop;
        i = 0;
        cyc = 0;
        stop = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        in_valid = start_with_valid;
        in_data  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0;
        while (!stop && i < TOTAL && cyc < 20000) begin
            in_valid = ($urandom_range(0, 99) >= gap_pct);
            in_data  = i;
            start    = (i == busy_start_at);
            abort    = in_valid && (i == abort_at);
            if (in_valid && i == reset_at) begin
                #2 reset = 1'b0;
                #1 check_reset_values();
                in_valid = 1'b0;
                start    = 1'b0;
                @(posedge clk); #1;
                reset = 1'b1;
                stop  = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (in_valid) i++;
                if (abort) stop = 1'b1;
            end
            cyc++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        abort    = 1'b0;
        check_eq("load_cycle_budget", (cyc < 20000) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset_values();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_eq("idle_abort_wins_ready", in_ready, 0);

        run_load(0, -1, -1, 1'b0, -1);
        check_eq("full_strobes", strobes, TOTAL);
        check_eq("full_dones", dones, 1);

        run_load(0, 345, -1, 1'b0, -1);
        check_eq("abort_strobes", strobes, TOTAL + 345);
        check_eq("abort_dones", dones, 1);

        run_load(50, -1, -1, 1'b1, 200);
        check_eq("bp_strobes", strobes, 2 * TOTAL + 345);
        check_eq("bp_dones", dones, 2);

        run_load(0, -1, 500, 1'b0, -1);
        check_eq("reset_strobes", strobes, 2 * TOTAL + 345 + 499);
        check_eq("reset_dones", dones, 2);
        check_eq("reset_no_reload", in_ready, 0);

        run_load(0, -1, -1, 1'b0, -1);
        check_eq("reload_strobes", strobes, 3 * TOTAL + 345 + 499);
        check_eq("reload_dones", dones, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
